// File: rtl/qsfp_module_ctrl_pkg.sv
// Shared state encoding and output-decode helpers for the QSFP cage control sequencer.
// Board status/LED logic decodes the `state` port using the same encoding.
package qsfp_module_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_INIT  = 2'd2,
    ST_READY = 2'd3
  } qsfp_state_t;

  // The module is released from reset and selected once past the ResetL dwell.
  function automatic logic module_released(input qsfp_state_t st);
    return (st == ST_INIT) || (st == ST_READY);
  endfunction

  function automatic logic lpmode_for(input qsfp_state_t st, input logic lp_req);
    return (st == ST_READY) ? lp_req : 1'b1;
  endfunction

endpackage

// File: rtl/qsfp_presence_debounce.sv
// Two-flop synchroniser plus stability-window debounce for the active-low ModPrsL pin.
// The debounced output only toggles after the synced pin disagrees for a full window.
module qsfp_presence_debounce #(
  parameter int DEBOUNCE_CYCLES = 125000
) (
  input  logic clk,
  input  logic rst,
  input  logic modprsl,
  output logic present
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          prs_meta;
  logic          prs_sync;
  logic [CW-1:0] cnt;
  logic          present_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prs_meta <= 1'b1;
      prs_sync <= 1'b1;
    end else begin
      prs_meta <= modprsl;
      prs_sync <= prs_meta;
    end
  end

  assign present_raw = ~prs_sync;

  // Any agreement restarts the window, so glitches shorter than it never land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      present <= 1'b0;
    end else if (present_raw == present) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt     <= '0;
      present <= ~present;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/qsfp_module_ctrl.sv
// Per-cage QSFP28 low-speed sequencer: debounced presence, timed ResetL pulse, init wait,
// then module_ready. All pin outputs are registered decodes of the next FSM state.
module qsfp_module_ctrl
  import qsfp_module_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES    = 1250,
  parameter int INIT_CYCLES     = 250000000,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int TIMER_WIDTH     = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       reset_req,
  input  logic       lp_mode_req,
  input  logic       modprsl,
  input  logic       intl,
  output logic       modsell,
  output logic       resetl,
  output logic       lpmode,
  output logic       module_present,
  output logic       module_ready,
  output logic       int_pulse,
  output logic [1:0] state
);

  localparam longint unsigned MAX_DWELL =
    (RESET_CYCLES > INIT_CYCLES) ? longint'(RESET_CYCLES) : longint'(INIT_CYCLES);

  if (((MAX_DWELL - 1) >> TIMER_WIDTH) != 0) begin : g_timer_too_narrow
    $error("qsfp_module_ctrl: TIMER_WIDTH cannot hold the longest dwell count");
  end

  qsfp_state_t            state_q;
  qsfp_state_t            state_d;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic [TIMER_WIDTH-1:0] timer_d;
  logic                   intl_meta;
  logic                   intl_sync;
  logic                   intl_prev;

  qsfp_presence_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_presence (
    .clk    (clk),
    .rst    (rst),
    .modprsl(modprsl),
    .present(module_present)
  );

  // Loss of enable/presence beats reset_req, which beats dwell expiry.
  always_comb begin
    state_d = state_q;
    if (!enable || !module_present) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_RESET;
        ST_RESET: if (timer_q == TIMER_WIDTH'(RESET_CYCLES - 1)) state_d = ST_INIT;
        ST_INIT: begin
          if (reset_req)                                        state_d = ST_RESET;
          else if (timer_q == TIMER_WIDTH'(INIT_CYCLES - 1))    state_d = ST_READY;
        end
        ST_READY: if (reset_req) state_d = ST_RESET;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) && ((state_q == ST_RESET) || (state_q == ST_INIT))) begin
      timer_d = timer_q + TIMER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      resetl       <= 1'b0;
      modsell      <= 1'b1;
      lpmode       <= 1'b1;
      module_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      resetl       <= module_released(state_d);
      modsell      <= ~module_released(state_d);
      lpmode       <= lpmode_for(state_d, lp_mode_req);
      module_ready <= (state_d == ST_READY);
    end
  end

  // Interrupt sync; the extra flop gives a falling-edge detector so a held-low pin pulses once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intl_meta <= 1'b1;
      intl_sync <= 1'b1;
      intl_prev <= 1'b1;
      int_pulse <= 1'b0;
    end else begin
      intl_meta <= intl;
      intl_sync <= intl_meta;
      intl_prev <= intl_sync;
      int_pulse <= intl_prev && !intl_sync && (state_q == ST_READY);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_qsfp_module_ctrl.sv
// Directed bench for qsfp_module_ctrl with short dwell parameters; expected values are
// hand-counted edges from reset release / stimulus changes.
module tb_qsfp_module_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       reset_req;
  logic       lp_mode_req;
  logic       modprsl;
  logic       intl;
  logic       modsell;
  logic       resetl;
  logic       lpmode;
  logic       module_present;
  logic       module_ready;
  logic       int_pulse;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int pcnt;

  qsfp_module_ctrl #(
    .RESET_CYCLES   (4),
    .INIT_CYCLES    (16),
    .DEBOUNCE_CYCLES(8),
    .TIMER_WIDTH    (28)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .reset_req     (reset_req),
    .lp_mode_req   (lp_mode_req),
    .modprsl       (modprsl),
    .intl          (intl),
    .modsell       (modsell),
    .resetl        (resetl),
    .lpmode        (lpmode),
    .module_present(module_present),
    .module_ready  (module_ready),
    .int_pulse     (int_pulse),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_modsell"}, 32'(modsell), 1);
    chk({tag, "_resetl"},  32'(resetl), 0);
    chk({tag, "_lpmode"},  32'(lpmode), 1);
    chk({tag, "_present"}, 32'(module_present), 0);
    chk({tag, "_ready"},   32'(module_ready), 0);
    chk({tag, "_intp"},    32'(int_pulse), 0);
    chk({tag, "_state"},   32'(state), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; modprsl = 1'b0; intl = 1'b1;
    reset_req = 1'b0; lp_mode_req = 1'b0;

    // power-up
    tick(2);
    chk_reset_vals("por");
    tick(3);
    rst = 1'b0;
    tick(9);
    chk("pu_present_early", 32'(module_present), 0);
    tick(1);
    chk("pu_present", 32'(module_present), 1);
    chk("pu_idle", 32'(state), 0);
    tick(1);
    chk("pu_reset_state", 32'(state), 1);
    chk("pu_reset_resetl", 32'(resetl), 0);
    tick(3);
    chk("pu_reset_last", 32'(state), 1);
    chk("pu_reset_last_resetl", 32'(resetl), 0);
    chk("pu_reset_last_modsell", 32'(modsell), 1);
    tick(1);
    chk("pu_init_state", 32'(state), 2);
    chk("pu_init_resetl", 32'(resetl), 1);
    chk("pu_init_modsell", 32'(modsell), 0);
    chk("pu_init_lpmode", 32'(lpmode), 1);
    chk("pu_init_ready", 32'(module_ready), 0);
    tick(15);
    chk("pu_init_last", 32'(state), 2);
    chk("pu_init_last_ready", 32'(module_ready), 0);
    tick(1);
    chk("pu_ready_state", 32'(state), 3);
    chk("pu_ready", 32'(module_ready), 1);
    chk("pu_ready_lpmode", 32'(lpmode), 0);

    // lp_mode tracking in READY
    lp_mode_req = 1'b1;
    tick(1);
    chk("lp_follow_hi", 32'(lpmode), 1);
    lp_mode_req = 1'b0;
    tick(1);
    chk("lp_follow_lo", 32'(lpmode), 0);

    // intl held low in READY: one pulse, three edges after the pin
    intl = 1'b0;
    tick(2);
    chk("int_before", 32'(int_pulse), 0);
    tick(1);
    chk("int_pulse", 32'(int_pulse), 1);
    pcnt = 0;
    repeat (17) begin
      tick(1);
      if (int_pulse) pcnt++;
    end
    chk("int_held_extra", 32'(pcnt), 0);
    intl = 1'b1;
    tick(3);

    // presence glitch shorter than the window
    modprsl = 1'b1;
    tick(5);
    modprsl = 1'b0;
    tick(10);
    chk("glitch_present", 32'(module_present), 1);
    chk("glitch_state", 32'(state), 3);
    chk("glitch_ready", 32'(module_ready), 1);

    // sustained removal
    modprsl = 1'b1;
    tick(9);
    chk("rm_present_early", 32'(module_present), 1);
    tick(1);
    chk("rm_present", 32'(module_present), 0);
    tick(1);
    chk("rm_state", 32'(state), 0);
    chk("rm_resetl", 32'(resetl), 0);
    chk("rm_ready", 32'(module_ready), 0);
    chk("rm_modsell", 32'(modsell), 1);

    // reinsertion, reset_req mid-INIT, intl activity during INIT
    modprsl = 1'b0;
    tick(10);
    chk("ri_present", 32'(module_present), 1);
    tick(1);
    chk("ri_reset", 32'(state), 1);
    tick(4);
    chk("ri_init", 32'(state), 2);
    intl = 1'b0;
    pcnt = 0;
    repeat (10) begin
      tick(1);
      if (int_pulse) pcnt++;
    end
    chk("int_in_init", 32'(pcnt), 0);
    intl = 1'b1;
    reset_req = 1'b1;
    tick(1);
    chk("rq_state", 32'(state), 1);
    chk("rq_resetl", 32'(resetl), 0);
    reset_req = 1'b0;
    lp_mode_req = 1'b1;
    tick(1);
    reset_req = 1'b1;
    tick(1);
    reset_req = 1'b0;
    chk("rq_ign_state", 32'(state), 1);
    chk("rq_lpmode_reset", 32'(lpmode), 1);
    tick(1);
    chk("rq_reset_last", 32'(state), 1);
    tick(1);
    chk("rq_init_state", 32'(state), 2);
    chk("rq_init_resetl", 32'(resetl), 1);
    tick(15);
    chk("rq_init_last", 32'(state), 2);
    chk("rq_lpmode_init", 32'(lpmode), 1);
    tick(1);
    chk("rq_ready", 32'(module_ready), 1);
    chk("rq_ready_lpmode", 32'(lpmode), 1);
    lp_mode_req = 1'b0;
    tick(1);
    chk("rq_ready_lp_lo", 32'(lpmode), 0);

    // enable fall together with reset_req: IDLE wins
    enable = 1'b0;
    reset_req = 1'b1;
    tick(1);
    chk("en_state", 32'(state), 0);
    chk("en_resetl", 32'(resetl), 0);
    chk("en_ready", 32'(module_ready), 0);
    reset_req = 1'b0;
    enable = 1'b1;
    tick(1);
    chk("en_reset", 32'(state), 1);
    tick(3);
    chk("en_reset_last", 32'(state), 1);
    tick(1);
    chk("en_init", 32'(state), 2);
    tick(15);
    chk("en_init_last", 32'(state), 2);
    tick(1);
    chk("en_ready_state", 32'(state), 3);
    chk("en_ready", 32'(module_ready), 1);

    // async reset mid-INIT
    reset_req = 1'b1;
    tick(1);
    reset_req = 1'b0;
    chk("ar_reset", 32'(state), 1);
    tick(4);
    chk("ar_init", 32'(state), 2);
    tick(3);
    #3 rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
